// File: rtl/fft_out_reorder.sv
// rtl/fft_out_reorder.sv - radix-4 digit-reversed to natural-order reorder buffer (ping-pong, 2 x N words)
// Optional drop counter port when FFT_REORDER_DROP_CNT_EN is defined.
module fft_out_reorder #(
  parameter int DATA_W = 16,
  parameter int N_LOG4 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_r,
  input  logic [DATA_W-1:0]     in_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_r,
  output logic [DATA_W-1:0]     out_i,
  output logic [2*N_LOG4-1:0]   out_idx,
  output logic                  out_last,
  output logic                  ovf_pulse,
  output logic                  ovf_flag
`ifdef FFT_REORDER_DROP_CNT_EN
  ,
  output logic [7:0]            drop_cnt
`endif
);

  localparam int ADDR_W = 2 * N_LOG4;
  localparam int N      = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_FETCH,
    RD_STREAM
  } rd_state_e;

  function automatic logic [ADDR_W-1:0] digit_rev(input logic [ADDR_W-1:0] c);
    logic [ADDR_W-1:0] r;
    r = '0;
    for (int d = 0; d < N_LOG4; d++) begin
      r[2*d +: 2] = c[ADDR_W-2-2*d +: 2];
    end
    return r;
  endfunction

  logic [2*DATA_W-1:0] mem [0:2*N-1];

  logic [1:0]          bank_full_q, bank_full_d;
  logic                wr_bank_q, wr_bank_d;
  logic [ADDR_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic                drop_q, drop_d;
  logic                ovf_flag_q, ovf_flag_d;

  rd_state_e           state_q, state_d;
  logic                rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [2*DATA_W-1:0] rd_data_q;

  logic                frame_start, start_free, ovf_pulse_c;
  logic                wr_en, wr_done;
  logic                rd_en, rd_free;
  logic [ADDR_W-1:0]   rd_addr;

  // A bank being released by the reader this very cycle is usable by a frame starting now.
  always_comb begin
    frame_start = in_valid && (wr_cnt_q == '0);
    start_free  = !bank_full_q[wr_bank_q] || (rd_free && (rd_bank_q == wr_bank_q));
    ovf_pulse_c = frame_start && !start_free;
    wr_en       = in_valid && (frame_start ? start_free : !drop_q);
    wr_done     = wr_en && (wr_cnt_q == LAST_IDX);
    wr_cnt_d    = in_valid ? wr_cnt_q + 1'b1 : wr_cnt_q;
    drop_d      = frame_start ? !start_free : drop_q;
    wr_bank_d   = wr_done ? ~wr_bank_q : wr_bank_q;
    ovf_flag_d  = ovf_flag_q | ovf_pulse_c;
    bank_full_d = bank_full_q;
    if (rd_free) begin
      bank_full_d[rd_bank_q] = 1'b0;
    end
    if (wr_done) begin
      bank_full_d[wr_bank_q] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    rd_bank_d   = rd_bank_q;
    rd_cnt_d    = rd_cnt_q;
    out_valid_d = out_valid_q;
    rd_en       = 1'b0;
    rd_addr     = rd_cnt_q;
    rd_free     = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (bank_full_q[rd_bank_q]) begin
          rd_en   = 1'b1;
          rd_addr = '0;
          state_d = RD_FETCH;
        end
      end
      RD_FETCH: begin
        out_valid_d = 1'b1;
        state_d     = RD_STREAM;
      end
      RD_STREAM: begin
        // Prefetch the next word on each transfer so the frame streams without bubbles.
        if (out_valid_q && out_ready) begin
          if (rd_cnt_q == LAST_IDX) begin
            rd_free     = 1'b1;
            rd_bank_d   = ~rd_bank_q;
            rd_cnt_d    = '0;
            out_valid_d = 1'b0;
            state_d     = RD_IDLE;
          end else begin
            rd_en    = 1'b1;
            rd_addr  = rd_cnt_q + 1'b1;
            rd_cnt_d = rd_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = RD_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_full_q <= '0;
      wr_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      drop_q      <= 1'b0;
      ovf_flag_q  <= 1'b0;
      state_q     <= RD_IDLE;
      rd_bank_q   <= 1'b0;
      rd_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      bank_full_q <= bank_full_d;
      wr_bank_q   <= wr_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      drop_q      <= drop_d;
      ovf_flag_q  <= ovf_flag_d;
      state_q     <= state_d;
      rd_bank_q   <= rd_bank_d;
      rd_cnt_q    <= rd_cnt_d;
      out_valid_q <= out_valid_d;
      if (rd_en) begin
        rd_data_q <= mem[{rd_bank_q, rd_addr}];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_bank_q, digit_rev(wr_cnt_q)}] <= {in_r, in_i};
    end
  end

`ifdef FFT_REORDER_DROP_CNT_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (ovf_pulse_c && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  assign out_valid = out_valid_q;
  assign out_r     = rd_data_q[2*DATA_W-1:DATA_W];
  assign out_i     = rd_data_q[DATA_W-1:0];
  assign out_idx   = rd_cnt_q;
  assign out_last  = (rd_cnt_q == LAST_IDX);
  assign ovf_pulse = ovf_pulse_c;
  assign ovf_flag  = ovf_flag_q;

endmodule
